pht_ctrl: RTL and testbench
===========================

Name: pht_ctrl

Overview:
- Access controller for the pattern history table (4 sets x 1024 entries x 2-bit counters, single port, one read or write per cycle).
- After reset it writes INIT_VAL into every entry.
- It then arbitrates between branch-prediction lookups and branch-resolution updates.
- Updates run as read-modify-write of a 2-bit saturating counter.

Parameters:
- SET_W, 2, set address width.
- TAB_W, 10, table index width.
- INIT_VAL, 2'b01, counter value written to every entry during initialisation (weakly not-taken).
- STARVE_LIMIT, 4, consecutive denied cycles of a pending update before it pre-empts lookups.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lk_req  in  1  lookup request; held until lk_ack.
- lk_set  in  SET_W  lookup set.
- lk_addr  in  TAB_W  lookup index.
- lk_ack  out  1  lookup accepted this cycle (combinational).
- lk_valid  out  1  lookup result valid (registered, 1 cycle after lk_ack).
- lk_ctr  out  2  counter value read.
- lk_pred  out  1  predict taken (lk_ctr[1]).
- up_req  in  1  update request; held until up_ack.
- up_set  in  SET_W  update set.
- up_addr  in  TAB_W  update index.
- up_taken  in  1  resolved branch direction.
- up_ack  out  1  update accepted this cycle (combinational).
- init_done  out  1  initialisation complete (registered).
- pht_wr_en  out  1  PHT write enable.
- pht_set_addr  out  SET_W  PHT set address.
- pht_tab_addr  out  TAB_W  PHT index.
- pht_up_data  out  2  PHT write data.
- pht_rd_data  in  2  PHT read data, valid the cycle after a read is presented.

Behaviour:
- PHT contract: a write takes effect at the clock edge. A read with pht_wr_en=0 returns data on pht_rd_data in the next cycle.

States:
- RST
  - Entered asynchronously whenever reset is low.
  - All outputs 0; init index = 0; starve count = 0.
  - Moves to INIT on the first edge after reset goes high.
- INIT
  - pht_wr_en=1, pht_up_data=INIT_VAL, {pht_tab_addr,pht_set_addr}=init index.
  - Index increments each cycle; set is the fastest-changing field.
  - After index 2^(SET_W+TAB_W)-1 is written, go to IDLE and set init_done=1. init_done stays 1 until reset.
  - lk_ack=up_ack=0 throughout; requests are ignored, not dropped (requesters hold them).
- IDLE
  - Grant update when up_req=1 and (lk_req=0 or starve count==STARVE_LIMIT).
    - up_ack=1; capture set, addr, taken.
    - Present PHT read at the update address.
    - Go to UP_WR; clear starve count.
  - Otherwise grant lookup when lk_req=1.
    - lk_ack=1; present PHT read at lookup address.
    - Stay in IDLE.
    - If up_req=1, starve count increments (saturates at STARVE_LIMIT).
  - Otherwise no PHT access: pht_wr_en=0, addresses hold their previous value.
- UP_WR
  - pht_wr_en=1 at the captured address.
  - pht_up_data = taken ? min(rd+1, 3) : max(rd-1, 0), where rd is pht_rd_data.
  - lk_ack=up_ack=0; return to IDLE.
  - If lk_req=1 and up_req=1 in UP_WR, the starve count does not change.

Lookup pipeline:
- Back-to-back lookups: one accepted per IDLE cycle.
- lk_valid=1 the cycle after each lk_ack, with lk_ctr=pht_rd_data and lk_pred=pht_rd_data[1]. lk_valid=0 otherwise.
- A lookup accepted in the IDLE cycle after UP_WR sees the newly written value (the write completed at the edge).
- Lookup result return and a new update read may overlap in the same cycle; the PHT read port is used only by the new request.

Reset mid-operation:
- Any state jumps to RST immediately.
- An in-flight UP_WR write is abandoned (pht_wr_en drops asynchronously).
- A pending lk_valid is cleared.
- init_done clears and initialisation restarts from index 0.

Width rules:
- Counter arithmetic is 2-bit saturating; wrap-around never occurs.
- Init index width is SET_W+TAB_W.

Test Plan:
1. Initialisation timing: release reset, then idle. Required: 4096 consecutive writes of 2'b01 in order (tab 0, set 0..3), (tab 1, set 0..3), ... ; init_done=1 exactly 4097 cycles after release; no ack during INIT despite lk_req=1.
2. Lookup after init: lookup set 2, addr 5. Required: lk_ack the same cycle, then lk_valid=1, lk_ctr=01, lk_pred=0 the next cycle.
3. Taken saturation: three taken updates to set 1, addr 3. Required: writes of 10, 11, 11, each update occupying 2 cycles; a following lookup returns lk_ctr=11, lk_pred=1.
4. Not-taken saturation: two not-taken updates to set 0, addr 7. Required: writes of 00 then 00.
5. Starvation limit: lk_req held high continuously with up_req asserted. Required: exactly 4 lookups acked, then up_ack on the 5th cycle; no lk_ack in the following UP_WR cycle; lookups resume afterwards.
6. Reset mid-update: assert reset during UP_WR. Required: pht_wr_en=0 immediately, all outputs 0; after release, INIT restarts writing from index 0 and init_done stays low until it completes.

Source files
------------

// File: rtl/pht_ctrl_if.sv
// Requester-side handshake bundle for the pattern history table controller.
// Carries the branch-prediction lookup channel and the branch-resolution update channel.
interface pht_ctrl_if #(
    parameter int SET_W = 2,
    parameter int TAB_W = 10
);
    logic             lk_req;
    logic [SET_W-1:0] lk_set;
    logic [TAB_W-1:0] lk_addr;
    logic             lk_ack;
    logic             lk_valid;
    logic [1:0]       lk_ctr;
    logic             lk_pred;

    logic             up_req;
    logic [SET_W-1:0] up_set;
    logic [TAB_W-1:0] up_addr;
    logic             up_taken;
    logic             up_ack;

    modport master (
        output lk_req, lk_set, lk_addr,
        output up_req, up_set, up_addr, up_taken,
        input  lk_ack, lk_valid, lk_ctr, lk_pred, up_ack
    );

    modport slave (
        input  lk_req, lk_set, lk_addr,
        input  up_req, up_set, up_addr, up_taken,
        output lk_ack, lk_valid, lk_ctr, lk_pred, up_ack
    );
endinterface

// File: rtl/pht_ctrl.sv
// Pattern history table access controller.
// Fills the table with INIT_VAL after reset, then arbitrates the single PHT port
// between lookups and read-modify-write updates of 2-bit saturating counters.
// A pending update that keeps losing to lookups takes the port after STARVE_LIMIT denials.
module pht_ctrl #(
    parameter int         SET_W        = 2,
    parameter int         TAB_W        = 10,
    parameter logic [1:0] INIT_VAL     = 2'b01,
    parameter int         STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    pht_ctrl_if.slave        bus,
    output logic             init_done,
    output logic             pht_wr_en,
    output logic [SET_W-1:0] pht_set_addr,
    output logic [TAB_W-1:0] pht_tab_addr,
    output logic [1:0]       pht_up_data,
    input  logic [1:0]       pht_rd_data
);
    localparam int IDX_W = SET_W + TAB_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RST,
        ST_INIT,
        ST_IDLE,
        ST_UP_WR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] init_idx;
    logic [CNT_W-1:0] starve_cnt;
    logic [SET_W-1:0] cap_set;
    logic [TAB_W-1:0] cap_addr;
    logic             cap_taken;
    logic [SET_W-1:0] last_set;
    logic [TAB_W-1:0] last_tab;
    logic             lk_valid_q;
    logic             grant_up;
    logic             grant_lk;
    logic [1:0]       bumped;

    // Saturating step of the counter being updated, based on the value read last cycle
    always_comb begin
        bumped = pht_rd_data;
        if (cap_taken) begin
            if (pht_rd_data != 2'b11) begin
                bumped = pht_rd_data + 2'b01;
            end
        end else if (pht_rd_data != 2'b00) begin
            bumped = pht_rd_data - 2'b01;
        end
    end

    // Next-state and PHT port drive; an idle port keeps the last presented address
    always_comb begin
        state_nxt    = state;
        grant_up     = 1'b0;
        grant_lk     = 1'b0;
        pht_wr_en    = 1'b0;
        pht_set_addr = last_set;
        pht_tab_addr = last_tab;
        pht_up_data  = 2'b00;
        case (state)
            ST_RST: begin
                pht_set_addr = '0;
                pht_tab_addr = '0;
                state_nxt    = ST_INIT;
            end
            ST_INIT: begin
                pht_wr_en    = 1'b1;
                pht_up_data  = INIT_VAL;
                pht_set_addr = init_idx[SET_W-1:0];
                pht_tab_addr = init_idx[IDX_W-1:SET_W];
                if (&init_idx) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.up_req && (!bus.lk_req || starve_cnt == STARVE_MAX)) begin
                    grant_up     = 1'b1;
                    pht_set_addr = bus.up_set;
                    pht_tab_addr = bus.up_addr;
                    state_nxt    = ST_UP_WR;
                end else if (bus.lk_req) begin
                    grant_lk     = 1'b1;
                    pht_set_addr = bus.lk_set;
                    pht_tab_addr = bus.lk_addr;
                end
            end
            ST_UP_WR: begin
                pht_wr_en    = 1'b1;
                pht_set_addr = cap_set;
                pht_tab_addr = cap_addr;
                pht_up_data  = bumped;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    assign bus.up_ack   = grant_up;
    assign bus.lk_ack   = grant_lk;
    assign bus.lk_valid = lk_valid_q;
    assign bus.lk_ctr   = lk_valid_q ? pht_rd_data : 2'b00;
    assign bus.lk_pred  = lk_valid_q & pht_rd_data[1];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Initialisation sweep index and the sticky completion flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_idx  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (&init_idx) begin
                init_done <= 1'b1;
            end
        end
    end

    // Remember the accepted update and the last address driven to the PHT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_set   <= '0;
            cap_addr  <= '0;
            cap_taken <= 1'b0;
            last_set  <= '0;
            last_tab  <= '0;
        end else begin
            last_set <= pht_set_addr;
            last_tab <= pht_tab_addr;
            if (grant_up) begin
                cap_set   <= bus.up_set;
                cap_addr  <= bus.up_addr;
                cap_taken <= bus.up_taken;
            end
        end
    end

    // Count lookups that won while an update was waiting; cleared when an update wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_up) begin
            starve_cnt <= '0;
        end else if (grant_lk && bus.up_req && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Lookup result is valid the cycle after acceptance, when the PHT read returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_valid_q <= 1'b0;
        end else begin
            lk_valid_q <= grant_lk;
        end
    end
endmodule

// File: tb/tb_pht_ctrl.sv
// Self-checking bench for pht_ctrl with a behavioural PHT and a scoreboard
// of expected lookup results and expected update writes.
module tb_pht_ctrl;
    localparam int SET_W = 2;
    localparam int TAB_W = 10;
    localparam int IDX_W = SET_W + TAB_W;
    localparam int N_ENT = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             init_done;
    logic             pht_wr_en;
    logic [SET_W-1:0] pht_set_addr;
    logic [TAB_W-1:0] pht_tab_addr;
    logic [1:0]       pht_up_data;
    logic [1:0]       pht_rd_data;

    pht_ctrl_if #(.SET_W(SET_W), .TAB_W(TAB_W)) bus ();

    pht_ctrl #(
        .SET_W(SET_W),
        .TAB_W(TAB_W),
        .INIT_VAL(2'b01),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .init_done(init_done),
        .pht_wr_en(pht_wr_en),
        .pht_set_addr(pht_set_addr),
        .pht_tab_addr(pht_tab_addr),
        .pht_up_data(pht_up_data),
        .pht_rd_data(pht_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-port PHT: write at the edge, read data one cycle later
    logic [1:0] pht_mem [N_ENT];
    always @(posedge clk) begin
        if (pht_wr_en) begin
            pht_mem[{pht_tab_addr, pht_set_addr}] <= pht_up_data;
        end else begin
            pht_rd_data <= pht_mem[{pht_tab_addr, pht_set_addr}];
        end
    end

    int num_checks = 0;
    int num_errors = 0;

    logic [1:0]  ref_mem [N_ENT];
    logic [1:0]  lk_q [$];
    logic [13:0] wr_q [$];

    logic       lk_ack_s, up_ack_s, wr_s, init_done_s, lk_valid_s, lk_pred_s;
    logic [1:0] lk_ctr_s, wr_data_s;
    logic       prev_lk_ack, prev_up_ack;
    int         init_wr_cnt, init_bad, init_ack_seen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sample_outputs();
        logic [1:0]       cur;
        logic [1:0]       nxt;
        logic [1:0]       exp_ctr;
        logic [13:0]      exp_wr;
        logic [IDX_W-1:0] idx;
        lk_ack_s    = bus.lk_ack;
        up_ack_s    = bus.up_ack;
        lk_valid_s  = bus.lk_valid;
        lk_ctr_s    = bus.lk_ctr;
        lk_pred_s   = bus.lk_pred;
        wr_s        = pht_wr_en;
        wr_data_s   = pht_up_data;
        init_done_s = init_done;
        if (!reset) begin
            lk_q.delete();
            wr_q.delete();
            for (int i = 0; i < N_ENT; i++) ref_mem[i] = 2'b01;
            init_wr_cnt   = 0;
            init_bad      = 0;
            init_ack_seen = 0;
            prev_lk_ack   = 1'b0;
            prev_up_ack   = 1'b0;
        end else if (!init_done) begin
            if (pht_wr_en) begin
                idx = {pht_tab_addr, pht_set_addr};
                if (idx != init_wr_cnt[IDX_W-1:0] || pht_up_data != 2'b01) init_bad++;
                init_wr_cnt++;
            end
            if (bus.lk_ack || bus.up_ack) init_ack_seen++;
            prev_lk_ack = 1'b0;
            prev_up_ack = 1'b0;
        end else begin
            checkOutput("lk_valid_timing", bus.lk_valid, prev_lk_ack);
            checkOutput("up_wr_timing", pht_wr_en, prev_up_ack);
            if (bus.lk_valid) begin
                if (lk_q.size() == 0) begin
                    checkOutput("lk_unexpected_valid", lk_q.size(), 1);
                end else begin
                    exp_ctr = lk_q.pop_front();
                    checkOutput("lk_ctr", bus.lk_ctr, exp_ctr);
                    checkOutput("lk_pred", bus.lk_pred, exp_ctr[1]);
                end
            end
            if (pht_wr_en) begin
                if (wr_q.size() == 0) begin
                    checkOutput("wr_unexpected", wr_q.size(), 1);
                end else begin
                    exp_wr = wr_q.pop_front();
                    checkOutput("up_write", {pht_set_addr, pht_tab_addr, pht_up_data}, exp_wr);
                end
            end
            if (bus.lk_ack) begin
                lk_q.push_back(ref_mem[{bus.lk_addr, bus.lk_set}]);
            end
            if (bus.up_ack) begin
                cur = ref_mem[{bus.up_addr, bus.up_set}];
                if (bus.up_taken) nxt = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
                else              nxt = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
                ref_mem[{bus.up_addr, bus.up_set}] = nxt;
                wr_q.push_back({bus.up_set, bus.up_addr, nxt});
            end
            prev_lk_ack = bus.lk_ack;
            prev_up_ack = bus.up_ack;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        sample_outputs();
        @(posedge clk);
        #1;
    endtask

    // Each run_cycle samples before its edge, so the sample that first sees
    // init_done has seen (cyc - 1) edges since reset release.
    task automatic run_init(input string tag);
        int cyc = 0;
        do begin
            run_cycle();
            cyc++;
        end while (!init_done_s && cyc < 5000);
        checkOutput({tag, "_done_edges"}, cyc - 1, 4097);
        checkOutput({tag, "_init_writes"}, init_wr_cnt, 4096);
        checkOutput({tag, "_init_order_bad"}, init_bad, 0);
        checkOutput({tag, "_ack_in_init"}, init_ack_seen, 0);
    endtask

    task automatic do_lookup(input logic [SET_W-1:0] s, input logic [TAB_W-1:0] a);
        int n = 0;
        bus.lk_req  = 1'b1;
        bus.lk_set  = s;
        bus.lk_addr = a;
        do begin
            run_cycle();
            n++;
        end while (!lk_ack_s && n < 50);
        checkOutput("lk_ack_wait", lk_ack_s, 1);
        bus.lk_req = 1'b0;
    endtask

    task automatic do_update(input logic [SET_W-1:0] s, input logic [TAB_W-1:0] a,
                             input logic taken, output int wait_cyc);
        int n = 0;
        bus.up_req   = 1'b1;
        bus.up_set   = s;
        bus.up_addr  = a;
        bus.up_taken = taken;
        do begin
            run_cycle();
            n++;
        end while (!up_ack_s && n < 50);
        checkOutput("up_ack_wait", up_ack_s, 1);
        bus.up_req = 1'b0;
        run_cycle();
        wait_cyc = n;
    endtask

    task automatic applyStimulus();
        int         n;
        int         n_lk;
        logic [1:0] t3_exp [3] = '{2'b10, 2'b11, 2'b11};

        // Reset with a lookup already pending; it must wait out the whole fill
        bus.lk_req   = 1'b1;
        bus.lk_set   = 2'd2;
        bus.lk_addr  = 10'd5;
        bus.up_req   = 1'b0;
        bus.up_set   = '0;
        bus.up_addr  = '0;
        bus.up_taken = 1'b0;
        repeat (3) run_cycle();
        checkOutput("t0_reset_init_done", init_done, 0);
        checkOutput("t0_reset_wr_en", pht_wr_en, 0);
        reset = 1'b1;
        run_init("t1");

        // Pending lookup set 2 addr 5 is granted in the first IDLE cycle
        checkOutput("t2_lk_ack_first_idle", lk_ack_s, 1);
        bus.lk_req = 1'b0;
        run_cycle();
        checkOutput("t2_lk_valid", lk_valid_s, 1);
        checkOutput("t2_lk_ctr", lk_ctr_s, 2'b01);
        checkOutput("t2_lk_pred", lk_pred_s, 0);

        // Taken updates saturate at 3
        for (int i = 0; i < 3; i++) begin
            do_update(2'd1, 10'd3, 1'b1, n);
            checkOutput("t3_ack_wait", n, 1);
            checkOutput("t3_wr_en", wr_s, 1);
            checkOutput("t3_wr_data", wr_data_s, t3_exp[i]);
        end
        do_lookup(2'd1, 10'd3);
        run_cycle();
        checkOutput("t3_lk_ctr", lk_ctr_s, 2'b11);
        checkOutput("t3_lk_pred", lk_pred_s, 1);

        // Not-taken updates saturate at 0
        for (int i = 0; i < 2; i++) begin
            do_update(2'd0, 10'd7, 1'b0, n);
            checkOutput("t4_wr_data", wr_data_s, 2'b00);
        end

        // Starvation: four lookups win, then the waiting update pre-empts
        bus.lk_req   = 1'b1;
        bus.lk_set   = 2'd3;
        bus.lk_addr  = 10'd9;
        bus.up_req   = 1'b1;
        bus.up_set   = 2'd3;
        bus.up_addr  = 10'd9;
        bus.up_taken = 1'b1;
        n = 0;
        n_lk = 0;
        do begin
            run_cycle();
            n++;
            if (lk_ack_s) n_lk++;
        end while (!up_ack_s && n < 20);
        checkOutput("t5_lookups_before_up", n_lk, 4);
        checkOutput("t5_up_ack_cycle", n, 5);
        bus.up_req = 1'b0;
        run_cycle();
        checkOutput("t5_no_lk_ack_in_upwr", lk_ack_s, 0);
        checkOutput("t5_upwr_data", wr_data_s, 2'b10);
        run_cycle();
        checkOutput("t5_lookup_resumes", lk_ack_s, 1);
        bus.lk_req = 1'b0;
        run_cycle();
        checkOutput("t5_new_value", lk_ctr_s, 2'b10);

        // Reset in the middle of an update write
        bus.up_req   = 1'b1;
        bus.up_set   = 2'd2;
        bus.up_addr  = 10'd1;
        bus.up_taken = 1'b1;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!up_ack_s && n < 50);
        checkOutput("t6_up_ack", up_ack_s, 1);
        bus.up_req = 1'b0;
        checkOutput("t6_wr_before_reset", pht_wr_en, 1);
        reset = 1'b0;
        #1;
        checkOutput("t6_wr_en_async", pht_wr_en, 0);
        checkOutput("t6_outputs_zero",
                    {pht_wr_en, init_done, bus.lk_valid, bus.lk_ctr, bus.lk_pred,
                     bus.lk_ack, bus.up_ack, pht_set_addr, pht_tab_addr, pht_up_data}, 0);
        repeat (3) run_cycle();
        reset = 1'b1;
        run_init("t6");

        // The earlier saturated entry is back at the fill value
        do_lookup(2'd1, 10'd3);
        run_cycle();
        checkOutput("t6_refilled_ctr", lk_ctr_s, 2'b01);
        run_cycle();
        checkOutput("lk_q_drained", lk_q.size(), 0);
        checkOutput("wr_q_drained", wr_q.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
